// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/MEM stages and the hazard block.
// master: pipeline side (drives ID fields, redirect); slave: hazard block.
interface pipe_hazard_ctrl_if #(
  parameter int RW = 5,
  parameter int CW = 16
);
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wr;
  logic [RW-1:0] id_rd;
  logic          id_load;
  logic          redirect;
  logic          stall;
  logic          flush_ifid;
  logic          ex_kill;
  logic          mem_kill;
  logic [1:0]    fwd_rs;
  logic [1:0]    fwd_rt;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output id_wr, id_rd, id_load,
    output redirect,
    input  stall, flush_ifid,
    input  ex_kill, mem_kill,
    input  fwd_rs, fwd_rt,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  id_wr, id_rd, id_load,
    input  redirect,
    output stall, flush_ifid,
    output ex_kill, mem_kill,
    output fwd_rs, fwd_rt,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush/bypass control for a 5-stage MIPS pipeline.
// Ports: clk, rst (sync, active-high), hz (slave side of the bundle).
module pipe_hazard_ctrl #(
  parameter int RW  = 5,
  parameter int FWD = 1,
  parameter int CW  = 16
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam bit FwdEn = (FWD != 0);

  typedef struct packed {
    logic          v;
    logic          wr;
    logic [RW-1:0] rd;
    logic          load;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          use_rs;
    logic          use_rt;
  } ex_t;

  // MEM keeps no load bit: load-use is resolved while the load is in EX.
  typedef struct packed {
    logic          v;
    logic          wr;
    logic [RW-1:0] rd;
  } pr_t;

  ex_t ex_q, ex_d;
  pr_t mem_q, mem_d;
  pr_t wb_q, wb_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;

  function automatic logic prod(
    input logic          v,
    input logic          wr,
    input logic [RW-1:0] rd,
    input logic [RW-1:0] r
  );
    return v & wr & (rd == r) & (r != '0);
  endfunction

  logic ex_p_rs, mem_p_rs, wb_p_rs;
  logic ex_p_rt, mem_p_rt, wb_p_rt;
  logic haz_rs, haz_rt, stall_w;

  assign ex_p_rs  = prod(ex_q.v, ex_q.wr, ex_q.rd, hz.id_rs);
  assign mem_p_rs = prod(mem_q.v, mem_q.wr, mem_q.rd, hz.id_rs);
  assign wb_p_rs  = prod(wb_q.v, wb_q.wr, wb_q.rd, hz.id_rs);
  assign ex_p_rt  = prod(ex_q.v, ex_q.wr, ex_q.rd, hz.id_rt);
  assign mem_p_rt = prod(mem_q.v, mem_q.wr, mem_q.rd, hz.id_rt);
  assign wb_p_rt  = prod(wb_q.v, wb_q.wr, wb_q.rd, hz.id_rt);

  // Forwarding only has to cover a load still in EX; without it
  // every in-flight producer blocks (no write-through regfile).
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    if (hz.id_valid) begin
      if (FwdEn) begin
        haz_rs = hz.id_use_rs & ex_p_rs & ex_q.load;
        haz_rt = hz.id_use_rt & ex_p_rt & ex_q.load;
      end else begin
        haz_rs = hz.id_use_rs &
                 (ex_p_rs | mem_p_rs | wb_p_rs);
        haz_rt = hz.id_use_rt &
                 (ex_p_rt | mem_p_rt | wb_p_rt);
      end
    end
  end

  assign stall_w = (haz_rs | haz_rt) & ~hz.redirect;

  logic m_rs, w_rs, m_rt, w_rt;
  logic [1:0] fsel_rs, fsel_rt;

  assign m_rs = prod(mem_q.v, mem_q.wr, mem_q.rd, ex_q.rs);
  assign w_rs = prod(wb_q.v, wb_q.wr, wb_q.rd, ex_q.rs);
  assign m_rt = prod(mem_q.v, mem_q.wr, mem_q.rd, ex_q.rt);
  assign w_rt = prod(wb_q.v, wb_q.wr, wb_q.rd, ex_q.rt);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    fsel_rs = 2'b00;
    fsel_rt = 2'b00;
    if (FwdEn) begin
      if (ex_q.use_rs) begin
        if (m_rs)      fsel_rs = 2'b01;
        else if (w_rs) fsel_rs = 2'b10;
      end
      if (ex_q.use_rt) begin
        if (m_rt)      fsel_rt = 2'b01;
        else if (w_rt) fsel_rt = 2'b10;
      end
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    wb_d  = mem_q;
    unique case (1'b1)
      hz.redirect: begin
        ex_d  = '0;
        mem_d = '0;
      end
      stall_w: begin
        ex_d  = '0;
        mem_d = '{v: ex_q.v, wr: ex_q.wr, rd: ex_q.rd};
      end
      default: begin
        ex_d = '{
          v:      hz.id_valid,
          wr:     hz.id_wr,
          rd:     hz.id_rd,
          load:   hz.id_load,
          rs:     hz.id_rs,
          rt:     hz.id_rt,
          use_rs: hz.id_use_rs,
          use_rt: hz.id_use_rt
        };
        mem_d = '{v: ex_q.v, wr: ex_q.wr, rd: ex_q.rd};
      end
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (stall_w && (scnt_q != '1))
      scnt_d = scnt_q + 1'b1;
    if (hz.redirect && (fcnt_q != '1))
      fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign hz.stall      = ~rst & stall_w;
  assign hz.flush_ifid = ~rst & hz.redirect;
  assign hz.ex_kill    = ~rst & (hz.redirect | stall_w);
  assign hz.mem_kill   = ~rst & hz.redirect;
  assign hz.fwd_rs     = rst ? 2'b00 : fsel_rs;
  assign hz.fwd_rt     = rst ? 2'b00 : fsel_rt;
  assign hz.stall_cnt  = rst ? '0 : scnt_q;
  assign hz.flush_cnt  = rst ? '0 : fcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding instance (CW=16) and an
// interlock instance (CW=4) share one directed ID/redirect stream.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       idv = 0, urs = 0, urt = 0, wr = 0, ld = 0, rdr = 0;
  logic [4:0] rs = 0, rt = 0, rd = 0;

  pipe_hazard_ctrl_if #(.RW(5), .CW(16)) if1 ();
  pipe_hazard_ctrl_if #(.RW(5), .CW(4))  if0 ();

  assign if1.id_valid  = idv;
  assign if1.id_rs     = rs;
  assign if1.id_rt     = rt;
  assign if1.id_use_rs = urs;
  assign if1.id_use_rt = urt;
  assign if1.id_wr     = wr;
  assign if1.id_rd     = rd;
  assign if1.id_load   = ld;
  assign if1.redirect  = rdr;
  assign if0.id_valid  = idv;
  assign if0.id_rs     = rs;
  assign if0.id_rt     = rt;
  assign if0.id_use_rs = urs;
  assign if0.id_use_rt = urt;
  assign if0.id_wr     = wr;
  assign if0.id_rd     = rd;
  assign if0.id_load   = ld;
  assign if0.redirect  = rdr;

  pipe_hazard_ctrl #(.RW(5), .FWD(1), .CW(16)) u_f1 (
    .clk(clk), .rst(rst), .hz(if1)
  );
  pipe_hazard_ctrl #(.RW(5), .FWD(0), .CW(4)) u_f0 (
    .clk(clk), .rst(rst), .hz(if0)
  );

  int checks = 0;
  int fails  = 0;

  // Model: d=0 is the forwarding instance, d=1 the interlock one.
  // Each in-flight slot is an instruction record; 0=EX,1=MEM,2=WB.
  typedef struct {
    bit v, wr, ld, urs, urt;
    int rd, rs, rt;
  } ins_t;

  ins_t pm[2][3];
  int   sc[2];
  int   fc[2];
  bit   fwdm[2] = '{1'b1, 1'b0};
  int   cmax[2] = '{65535, 15};
  string nm[8] = '{"stall", "flush_ifid", "ex_kill", "mem_kill",
                   "fwd_rs", "fwd_rt", "stall_cnt", "flush_cnt"};

  function automatic bit produces(ins_t e, int r);
    return e.v && e.wr && e.rd == r && r != 0;
  endfunction

  function automatic bit src_haz(int d, int s, bit u);
    if (!(u && idv && s != 0)) return 0;
    if (fwdm[d]) return produces(pm[d][0], s) && pm[d][0].ld;
    for (int k = 0; k < 3; k++)
      if (produces(pm[d][k], s)) return 1;
    return 0;
  endfunction

  function automatic bit m_stall(int d);
    return (src_haz(d, int'(rs), urs) || src_haz(d, int'(rt), urt))
           && !rdr;
  endfunction

  function automatic int m_fwd(int d, int r, bit u);
    if (!fwdm[d] || !u) return 0;
    if (produces(pm[d][1], r)) return 1;
    if (produces(pm[d][2], r)) return 2;
    return 0;
  endfunction

  function automatic int expv(int d, int k);
    if (rst) return 0;
    case (k)
      0: return int'(m_stall(d));
      1: return int'(rdr);
      2: return int'(rdr || m_stall(d));
      3: return int'(rdr);
      4: return m_fwd(d, pm[d][0].rs, pm[d][0].urs);
      5: return m_fwd(d, pm[d][0].rt, pm[d][0].urt);
      6: return sc[d];
      default: return fc[d];
    endcase
  endfunction

  function automatic int gotv(int d, int k);
    if (d == 0) begin
      case (k)
        0: return int'(if1.stall);
        1: return int'(if1.flush_ifid);
        2: return int'(if1.ex_kill);
        3: return int'(if1.mem_kill);
        4: return int'(if1.fwd_rs);
        5: return int'(if1.fwd_rt);
        6: return int'(if1.stall_cnt);
        default: return int'(if1.flush_cnt);
      endcase
    end
    case (k)
      0: return int'(if0.stall);
      1: return int'(if0.flush_ifid);
      2: return int'(if0.ex_kill);
      3: return int'(if0.mem_kill);
      4: return int'(if0.fwd_rs);
      5: return int'(if0.fwd_rt);
      6: return int'(if0.stall_cnt);
      default: return int'(if0.flush_cnt);
    endcase
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) pm[d][k] = '{default: 0};
        sc[d] = 0;
        fc[d] = 0;
      end else begin
        bit st;
        ins_t nw;
        st = m_stall(d);
        if (st && sc[d] < cmax[d]) sc[d]++;
        if (rdr && fc[d] < cmax[d]) fc[d]++;
        nw = '{v: idv, wr: wr, ld: ld, urs: urs, urt: urt,
               rd: int'(rd), rs: int'(rs), rt: int'(rt)};
        pm[d][2] = pm[d][1];
        pm[d][1] = rdr ? '{default: 0} : pm[d][0];
        pm[d][0] = (rdr || st) ? '{default: 0} : nw;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (gotv(d, k) != expv(d, k)) begin
          fails++;
          $display("FAIL cyc u%0d.%s got=%0d exp=%0d t=%0t",
                   d, nm[k], gotv(d, k), expv(d, k), $time);
        end
      end
  end

  task automatic lit(string n, int g, int e);
    checks++;
    if (g != e) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", n, g, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id(bit v, int s, int t, bit us, bit ut,
                    bit w, int d, bit l);
    idv = v; rs = 5'(s); rt = 5'(t); urs = us; urt = ut;
    wr = w; rd = 5'(d); ld = l;
    #1;
  endtask

  task automatic nop();
    id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) cyc();
    lit("rst_stall_out", int'(if1.stall), 0);
    rst = 1'b0;
    #1;
    lit("post_rst_scnt", int'(if1.stall_cnt), 0);
    lit("post_rst_fcnt", int'(if0.flush_cnt), 0);

    // FWD=1 ALU chain: add r3 / sub r4,r3,r5 / or r7,r3,r0
    id(1, 1, 2, 1, 1, 1, 3, 0);
    cyc();
    id(1, 3, 5, 1, 1, 1, 4, 0);
    lit("alu_nostall", int'(if1.stall), 0);
    cyc();
    id(1, 3, 0, 1, 1, 1, 7, 0);
    lit("fwd_mem", int'(if1.fwd_rs), 1);
    lit("fwd_mem_rt", int'(if1.fwd_rt), 0);
    cyc();
    nop();
    lit("fwd_wb", int'(if1.fwd_rs), 2);
    lit("fwd_r0", int'(if1.fwd_rt), 0);
    drain();

    // FWD=1 load-use: lw r2 / add r4,r2,r2
    id(1, 1, 0, 1, 0, 1, 2, 1);
    cyc();
    id(1, 2, 2, 1, 1, 1, 4, 0);
    lit("lu_stall", int'(if1.stall), 1);
    lit("lu_exkill", int'(if1.ex_kill), 1);
    cyc();
    lit("lu_release", int'(if1.stall), 0);
    cyc();
    nop();
    lit("lu_fwd_rs", int'(if1.fwd_rs), 2);
    lit("lu_fwd_rt", int'(if1.fwd_rt), 2);
    lit("lu_scnt", int'(if1.stall_cnt), 1);
    drain();

    // FWD=0 interlock: add r3 / or r6,r3,r0 -> 3 stalls
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    id(1, 1, 2, 1, 1, 1, 3, 0);
    cyc();
    id(1, 3, 0, 1, 1, 1, 6, 0);
    lit("il_stall1", int'(if0.stall), 1);
    cyc();
    lit("il_stall2", int'(if0.stall), 1);
    cyc();
    lit("il_stall3", int'(if0.stall), 1);
    lit("il_fwd", int'(if0.fwd_rs), 0);
    cyc();
    lit("il_issue", int'(if0.stall), 0);
    cyc();
    nop();
    lit("il_scnt", int'(if0.stall_cnt), 3);
    drain();

    // r0 dependency in both modes
    id(1, 1, 2, 1, 1, 1, 0, 0);
    cyc();
    id(1, 0, 0, 1, 1, 1, 5, 0);
    lit("r0_f0_stall", int'(if0.stall), 0);
    lit("r0_f1_stall", int'(if1.stall), 0);
    cyc();
    nop();
    lit("r0_fwd", int'(if1.fwd_rs), 0);
    drain();

    // redirect on top of a load-use hazard
    id(1, 1, 0, 1, 0, 1, 2, 1);
    cyc();
    id(1, 2, 2, 1, 1, 1, 4, 0);
    rdr = 1'b1;
    #1;
    lit("rd_stall", int'(if1.stall), 0);
    lit("rd_flush", int'(if1.flush_ifid), 1);
    lit("rd_exkill", int'(if1.ex_kill), 1);
    lit("rd_memkill", int'(if1.mem_kill), 1);
    cyc();
    rdr = 1'b0;
    nop();
    lit("rd_fcnt", int'(if1.flush_cnt), 1);
    id(1, 2, 2, 1, 1, 1, 8, 0);
    lit("rd_nostall_f1", int'(if1.stall), 0);
    lit("rd_nostall_f0", int'(if0.stall), 0);
    cyc();
    nop();
    lit("rd_nofwd", int'(if1.fwd_rs), 0);
    drain();

    // saturation on the CW=4 instance, then reset mid-stall
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    id(1, 3, 3, 1, 1, 1, 3, 0);
    repeat (31) cyc();
    lit("sat_midstall", int'(if0.stall), 1);
    lit("sat_cnt", int'(if0.stall_cnt), 15);
    rst = 1'b1;
    #1;
    lit("rst_forced_stall", int'(if0.stall), 0);
    lit("rst_forced_cnt", int'(if0.stall_cnt), 0);
    cyc();
    rst = 1'b0;
    #1;
    lit("after_rst_stall", int'(if0.stall), 0);
    lit("after_rst_exkill", int'(if0.ex_kill), 0);
    lit("after_rst_cnt", int'(if0.stall_cnt), 0);
    cyc();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
